mont_ram_client: RTL and testbench
==================================

// Module: mont_ram_client
// PURPOSE
//  Hardware-side end of the 512-bit software/hardware RAM bridge. Collects three operand batches (A, B, M),
//  each a dout_hw_valid pulse, and runs the Montgomery core(s). Writes the result back via we_hw/din_hw,
//  waiting for din_hw_read, then pulses irq to the processor. Sits between the bridge RAM and the cores.
// PARAMETERS
//  NUM_OF_CORES  1    cores served (1 or 2); lane k uses dout_hwk/din_hwk/we_hwk
//  OPW           512  operand width per lane
// PORTS
//  clk             in   1                clock
//  resetn          in   1                synchronous reset, active-low
//  dout_hw1        in   OPW              lane-1 operand from bridge RAM
//  dout_hw2        in   OPW              lane-2 operand (ignored when NUM_OF_CORES==1)
//  dout_hw_valid   in   1                1-cycle pulse: software finished a batch
//  din_hw1         out  OPW              lane-1 result to bridge RAM
//  din_hw2         out  OPW              lane-2 result (0 when NUM_OF_CORES==1)
//  we_hw1          out  1                write request lane 1
//  we_hw2          out  1                write request lane 2 (0 when NUM_OF_CORES==1)
//  din_hw_read     in   1                bridge accepted the result write
//  core_a/b/m      out  NUM_OF_CORES*OPW latched operands, lane k at [k*OPW +: OPW]
//  core_start      out  1                1-cycle start pulse to all cores
//  core_done       in   NUM_OF_CORES     per-core done pulse
//  core_result     in   NUM_OF_CORES*OPW per-core result, valid in its done cycle
//  busy            out  1                high in every state except IDLE
//  irq             out  1                1-cycle pulse when write-back is accepted
//  err_overrun     out  1                sticky: dout_hw_valid seen outside a LOAD state
//  cycle_count     out  32               cycles from core_start to the last core_done
// BEHAVIOUR
//  - Reset (resetn==0 at posedge): state=IDLE. All outputs, operand regs, done flags and result regs go to 0.
//    Applies mid-operation too: no write-back, no irq.
//  - States: IDLE/LOAD_A -> LOAD_B -> LOAD_M -> START -> WAIT -> WRITE -> DONE -> IDLE.
//    IDLE also acts as LOAD_A: on dout_hw_valid, latch dout_hw* into a and go to LOAD_B.
//    LOAD_B/LOAD_M: on dout_hw_valid, latch into b / m. LOAD_M then goes to START.
//  - Operands are sampled in the dout_hw_valid cycle itself.
//  - START lasts one cycle: core_start=1, cycle_count cleared to 0. Next state is WAIT.
//  - WAIT: cycle_count += 1 per cycle, saturating at 32'hFFFF_FFFF.
//    core_done[k] sets done flag k and captures core_result lane k. Cores may finish in any order or the same cycle.
//    Done pulses arriving in any other state are ignored.
//    Leave WAIT at the edge where all flags are set, counting that cycle.
//  - WRITE: din_hwk = captured result k; we_hwk=1 for every active lane, held until din_hw_read=1.
//    A software write takes bridge priority, so din_hw_read may arrive any number of cycles later.
//    Repeated identical writes are harmless. we_hw* drop at the edge after din_hw_read is seen.
//  - DONE lasts one cycle: irq=1, done flags cleared. Next state is IDLE. irq is never asserted elsewhere.
//  - dout_hw_valid in START/WAIT/WRITE/DONE: ignored, err_overrun <= 1. Only reset clears it.
//  - core_a/b/m hold their values until the next load overwrites them.
//  - Widths are exact; there is no arithmetic on operands.
// STRUCTURE
//  Package mont_if_pkg: state encoding localparams (3-bit), OPW, CNT_W=32.
//  Sub-module mont_result_latch, one per core (generate): done flag + OPW result register,
//  with set on done-in-WAIT and clear on DONE or reset.
// TESTING
//  1 core: valid with A=1, B=2, M=3 -> core_a/b/m=1/2/3; core_start high exactly 1 cycle after the 3rd valid.
//  1 core: done 10 cycles after start, result=0xABC -> cycle_count=10; din_hw1=0xABC, we_hw1 high
//   until din_hw_read; irq high 1 cycle; busy=0 after.
//  2 cores: done[1] at +5, done[0] at +9 -> both results captured, we_hw1 and we_hw2 asserted together,
//   cycle_count=9.
//  Write-back stall: din_hw_read held 0 for 7 cycles -> we_hw* stay 1, no irq until the read is seen.
//  Overrun: dout_hw_valid pulsed in WAIT -> err_overrun=1 and stays 1; operands unchanged.
//  resetn=0 in WAIT and again in WRITE -> all outputs 0, IDLE, no irq; a fresh 3-batch sequence completes normally.

Source files
------------

// File: rtl/mont_if_pkg.sv
// Shared definitions for the Montgomery RAM-bridge client: state encoding,
// default operand width, cycle counter width and a saturating increment.
package mont_if_pkg;

  localparam int OPW   = 512;
  localparam int CNT_W = 32;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // 3-bit state encoding; IDLE doubles as LOAD_A.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_LOAD_M = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_WRITE  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // Increment that sticks at the maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/mont_result_latch.sv
// Per-core completion tracker: remembers that a core has finished and holds
// the result it presented in its done cycle until the write-back is over.
module mont_result_latch
  import mont_if_pkg::*;
#(
  parameter int W = 512
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         set_en,
  input  logic         clr,
  input  logic [W-1:0] result_in,
  output logic         done_flag,
  output logic [W-1:0] result
);

  // Capture on a qualified done pulse; drop the flag once the job is retired.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      done_flag <= 1'b0;
      result    <= {W{1'b0}};
    end else if (clr) begin
      done_flag <= 1'b0;
    end else if (set_en) begin
      done_flag <= 1'b1;
      result    <= result_in;
    end
  end

endmodule

// File: rtl/mont_ram_client.sv
// Hardware end of the software/hardware RAM bridge: gathers the A, B and M
// operand batches, kicks the Montgomery core(s), waits for every core to
// finish, writes the results back through the bridge and raises irq.
module mont_ram_client
  import mont_if_pkg::*;
#(
  parameter int NUM_OF_CORES = 1,
  parameter int OPW          = mont_if_pkg::OPW
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [OPW-1:0]              dout_hw1,
  input  logic [OPW-1:0]              dout_hw2,
  input  logic                        dout_hw_valid,
  output logic [OPW-1:0]              din_hw1,
  output logic [OPW-1:0]              din_hw2,
  output logic                        we_hw1,
  output logic                        we_hw2,
  input  logic                        din_hw_read,
  output logic [NUM_OF_CORES*OPW-1:0] core_a,
  output logic [NUM_OF_CORES*OPW-1:0] core_b,
  output logic [NUM_OF_CORES*OPW-1:0] core_m,
  output logic                        core_start,
  input  logic [NUM_OF_CORES-1:0]     core_done,
  input  logic [NUM_OF_CORES*OPW-1:0] core_result,
  output logic                        busy,
  output logic                        irq,
  output logic                        err_overrun,
  output logic [CNT_W-1:0]            cycle_count
);

  localparam int   LW   = NUM_OF_CORES * OPW;
  localparam logic DUAL = (NUM_OF_CORES == 2);

  state_t state_r;

  logic [LW-1:0]           dout_all_s;
  logic [LW-1:0]           res_q_s;
  logic [LW-1:0]           res_next_s;
  logic [OPW-1:0]          lane2_next_s;
  logic [NUM_OF_CORES-1:0] set_en_s;
  logic [NUM_OF_CORES-1:0] flag_s;
  logic                    all_done_s;
  logic                    clr_s;
  logic                    overrun_s;

  // Lane packing of the incoming operands and the second write-back lane.
  generate
    if (NUM_OF_CORES == 2) begin : g_dual
      assign dout_all_s   = {dout_hw2, dout_hw1};
      assign lane2_next_s = res_next_s[2*OPW-1:OPW];
    end else begin : g_single
      logic unused_lane2_s;
      assign dout_all_s     = dout_hw1;
      assign lane2_next_s   = {OPW{1'b0}};
      assign unused_lane2_s = ^dout_hw2;
    end
  endgenerate

  // Done pulses only count while the cores are being waited on.
  assign set_en_s   = core_done & {NUM_OF_CORES{state_r == ST_WAIT}};
  assign clr_s      = (state_r == ST_DONE);
  assign all_done_s = &(flag_s | set_en_s);

  // A batch arriving while a job is in flight is an overrun.
  assign overrun_s = dout_hw_valid &&
                     (state_r != ST_IDLE) && (state_r != ST_LOAD_B) && (state_r != ST_LOAD_M);

  // One result latch per core; the "next" view folds in a same-cycle capture
  // so the write-back register can load on the final done edge.
  generate
    for (genvar k = 0; k < NUM_OF_CORES; k++) begin : g_lat
      mont_result_latch #(.W(OPW)) u_lat (
        .clk       (clk),
        .resetn    (resetn),
        .set_en    (set_en_s[k]),
        .clr       (clr_s),
        .result_in (core_result[k*OPW +: OPW]),
        .done_flag (flag_s[k]),
        .result    (res_q_s[k*OPW +: OPW])
      );
      assign res_next_s[k*OPW +: OPW] = set_en_s[k] ? core_result[k*OPW +: OPW]
                                                    : res_q_s[k*OPW +: OPW];
    end
  endgenerate

  // Control FSM with all bridge/core-facing outputs registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      core_a      <= {LW{1'b0}};
      core_b      <= {LW{1'b0}};
      core_m      <= {LW{1'b0}};
      core_start  <= 1'b0;
      busy        <= 1'b0;
      irq         <= 1'b0;
      err_overrun <= 1'b0;
      cycle_count <= {CNT_W{1'b0}};
      din_hw1     <= {OPW{1'b0}};
      din_hw2     <= {OPW{1'b0}};
      we_hw1      <= 1'b0;
      we_hw2      <= 1'b0;
    end else begin
      core_start <= 1'b0;
      irq        <= 1'b0;
      if (overrun_s) begin
        err_overrun <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (dout_hw_valid) begin
            core_a  <= dout_all_s;
            busy    <= 1'b1;
            state_r <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (dout_hw_valid) begin
            core_b  <= dout_all_s;
            state_r <= ST_LOAD_M;
          end
        end
        ST_LOAD_M: begin
          if (dout_hw_valid) begin
            core_m      <= dout_all_s;
            core_start  <= 1'b1;
            cycle_count <= {CNT_W{1'b0}};
            state_r     <= ST_START;
          end
        end
        ST_START: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          cycle_count <= sat_inc(cycle_count);
          if (all_done_s) begin
            din_hw1 <= res_next_s[OPW-1:0];
            din_hw2 <= lane2_next_s;
            we_hw1  <= 1'b1;
            we_hw2  <= DUAL;
            state_r <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (din_hw_read) begin
            we_hw1  <= 1'b0;
            we_hw2  <= 1'b0;
            irq     <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          we_hw1  <= 1'b0;
          we_hw2  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_ram_client.sv
// Directed bench for mont_ram_client: a single-core and a dual-core instance
// driven through load, compute, write-back stall, overrun and reset cases.
module tb_mont_ram_client;

  localparam int OPW = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // single-core instance signals
  logic             s_resetn, s_valid, s_read, s_done;
  logic [OPW-1:0]   s_dout1, s_dout2, s_result;
  logic [OPW-1:0]   s_din1, s_din2, s_a, s_b, s_m;
  logic             s_we1, s_we2, s_start, s_busy, s_irq, s_err;
  logic [31:0]      s_cnt;

  // dual-core instance signals
  logic             d_resetn, d_valid, d_read;
  logic [1:0]       d_done;
  logic [OPW-1:0]   d_dout1, d_dout2, d_din1, d_din2;
  logic [2*OPW-1:0] d_result, d_a, d_b, d_m;
  logic             d_we1, d_we2, d_start, d_busy, d_irq, d_err;
  logic [31:0]      d_cnt;

  int checks = 0;
  int errors = 0;

  mont_ram_client #(.NUM_OF_CORES(1), .OPW(OPW)) dut_s (
    .clk(clk), .resetn(s_resetn), .dout_hw1(s_dout1), .dout_hw2(s_dout2),
    .dout_hw_valid(s_valid), .din_hw1(s_din1), .din_hw2(s_din2),
    .we_hw1(s_we1), .we_hw2(s_we2), .din_hw_read(s_read),
    .core_a(s_a), .core_b(s_b), .core_m(s_m), .core_start(s_start),
    .core_done(s_done), .core_result(s_result), .busy(s_busy), .irq(s_irq),
    .err_overrun(s_err), .cycle_count(s_cnt)
  );

  mont_ram_client #(.NUM_OF_CORES(2), .OPW(OPW)) dut_d (
    .clk(clk), .resetn(d_resetn), .dout_hw1(d_dout1), .dout_hw2(d_dout2),
    .dout_hw_valid(d_valid), .din_hw1(d_din1), .din_hw2(d_din2),
    .we_hw1(d_we1), .we_hw2(d_we2), .din_hw_read(d_read),
    .core_a(d_a), .core_b(d_b), .core_m(d_m), .core_start(d_start),
    .core_done(d_done), .core_result(d_result), .busy(d_busy), .irq(d_irq),
    .err_overrun(d_err), .cycle_count(d_cnt)
  );

  task automatic chk(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic s_batch(input logic [OPW-1:0] v);
    s_valid = 1'b1;
    s_dout1 = v;
    step();
    s_valid = 1'b0;
  endtask

  task automatic d_batch(input logic [OPW-1:0] v1, input logic [OPW-1:0] v2);
    d_valid = 1'b1;
    d_dout1 = v1;
    d_dout2 = v2;
    step();
    d_valid = 1'b0;
  endtask

  initial begin
    s_resetn = 1'b0; s_valid = 1'b0; s_read = 1'b0; s_done = 1'b0;
    s_dout1 = '0; s_dout2 = '0; s_result = '0;
    d_resetn = 1'b0; d_valid = 1'b0; d_read = 1'b0; d_done = 2'b00;
    d_dout1 = '0; d_dout2 = '0; d_result = '0;
    step(); step();

    // reset state
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_irq", s_irq, 1'b0);
    chk("rst_start", s_start, 1'b0);
    chk("rst_a", s_a, 512'h0);
    chk("rst_cnt", s_cnt, 32'd0);
    chk("rst_we1", s_we1, 1'b0);
    chk("rst_err", s_err, 1'b0);
    chk("rst_d_busy", d_busy, 1'b0);
    chk("rst_d_we2", d_we2, 1'b0);

    s_resetn = 1'b1; d_resetn = 1'b1;
    step();
    chk("idle_busy", s_busy, 1'b0);

    // single core: A=1, B=2, M=3
    s_batch(512'h1);
    chk("loadb_busy", s_busy, 1'b1);
    chk("loadb_a", s_a, 512'h1);
    chk("loadb_start", s_start, 1'b0);
    s_batch(512'h2);
    s_batch(512'h3);
    chk("start_pulse", s_start, 1'b1);
    chk("start_a", s_a, 512'h1);
    chk("start_b", s_b, 512'h2);
    chk("start_m", s_m, 512'h3);
    chk("start_cnt", s_cnt, 32'd0);
    step();
    chk("start_once", s_start, 1'b0);
    repeat (9) step();
    chk("wait_we1", s_we1, 1'b0);
    s_done = 1'b1; s_result = 512'hABC;
    step();
    s_done = 1'b0;
    chk("wr_we1", s_we1, 1'b1);
    chk("wr_din1", s_din1, 512'hABC);
    chk("wr_cnt10", s_cnt, 32'd10);
    chk("wr_we2_single", s_we2, 1'b0);
    chk("wr_din2_single", s_din2, 512'h0);
    chk("wr_irq", s_irq, 1'b0);

    // write-back stall: no read for 7 more cycles
    for (int i = 0; i < 7; i++) begin
      step();
      chk("stall_we1", s_we1, 1'b1);
      chk("stall_irq", s_irq, 1'b0);
    end
    s_read = 1'b1;
    step();
    s_read = 1'b0;
    chk("done_irq", s_irq, 1'b1);
    chk("done_we1", s_we1, 1'b0);
    step();
    chk("after_irq", s_irq, 1'b0);
    chk("after_busy", s_busy, 1'b0);

    // overrun during WAIT
    s_batch(512'h5);
    s_batch(512'h6);
    s_batch(512'h7);
    step();
    s_valid = 1'b1; s_dout1 = 512'hFF;
    step();
    s_valid = 1'b0;
    chk("ovr_err", s_err, 1'b1);
    chk("ovr_a", s_a, 512'h5);
    chk("ovr_b", s_b, 512'h6);
    chk("ovr_m", s_m, 512'h7);
    step();
    s_done = 1'b1; s_result = 512'h77;
    step();
    s_done = 1'b0;
    chk("ovr_cnt3", s_cnt, 32'd3);
    chk("ovr_din1", s_din1, 512'h77);
    s_read = 1'b1;
    step();
    s_read = 1'b0;
    chk("ovr_irq", s_irq, 1'b1);
    step();
    chk("ovr_sticky", s_err, 1'b1);

    // reset while in WAIT
    s_batch(512'h8);
    s_batch(512'h9);
    s_batch(512'hA);
    step(); step();
    s_resetn = 1'b0;
    step();
    chk("rstw_busy", s_busy, 1'b0);
    chk("rstw_a", s_a, 512'h0);
    chk("rstw_err", s_err, 1'b0);
    chk("rstw_cnt", s_cnt, 32'd0);
    s_resetn = 1'b1;

    // reset while in WRITE
    s_batch(512'h8);
    s_batch(512'h9);
    s_batch(512'hA);
    step();
    s_done = 1'b1; s_result = 512'h123;
    step();
    s_done = 1'b0;
    chk("rstr_pre_we1", s_we1, 1'b1);
    s_resetn = 1'b0;
    step();
    chk("rstr_we1", s_we1, 1'b0);
    chk("rstr_din1", s_din1, 512'h0);
    chk("rstr_irq", s_irq, 1'b0);
    s_resetn = 1'b1;
    step();
    chk("rstr_irq2", s_irq, 1'b0);
    chk("rstr_busy", s_busy, 1'b0);

    // stray done in IDLE must be ignored; then a fresh job completes
    s_done = 1'b1; s_result = 512'hDEAD;
    step();
    s_done = 1'b0;
    s_batch(512'h1111);
    s_batch(512'h2222);
    s_batch(512'h3333);
    chk("fresh_a", s_a, 512'h1111);
    chk("fresh_m", s_m, 512'h3333);
    step(); step();
    chk("fresh_wait_we1", s_we1, 1'b0);
    s_done = 1'b1; s_result = 512'h4444;
    step();
    s_done = 1'b0;
    chk("fresh_cnt2", s_cnt, 32'd2);
    chk("fresh_din1", s_din1, 512'h4444);
    s_read = 1'b1;
    step();
    s_read = 1'b0;
    chk("fresh_irq", s_irq, 1'b1);
    step();
    chk("fresh_busy", s_busy, 1'b0);

    // dual core: done[1] at +5, done[0] at +9
    d_batch(512'h11, 512'h21);
    d_batch(512'h12, 512'h22);
    d_batch(512'h13, 512'h23);
    chk("d_start", d_start, 1'b1);
    chk("d_a_lo", d_a[OPW-1:0], 512'h11);
    chk("d_a_hi", d_a[2*OPW-1:OPW], 512'h21);
    chk("d_m_hi", d_m[2*OPW-1:OPW], 512'h23);
    step();
    repeat (4) step();
    d_done = 2'b10; d_result = {512'h55, 512'h0};
    step();
    d_done = 2'b00;
    chk("d_half_we1", d_we1, 1'b0);
    repeat (3) step();
    d_done = 2'b01; d_result = {512'hEE, 512'h99};
    step();
    d_done = 2'b00;
    chk("d_we1", d_we1, 1'b1);
    chk("d_we2", d_we2, 1'b1);
    chk("d_din1", d_din1, 512'h99);
    chk("d_din2", d_din2, 512'h55);
    chk("d_cnt9", d_cnt, 32'd9);
    d_read = 1'b1;
    step();
    d_read = 1'b0;
    chk("d_irq", d_irq, 1'b1);
    chk("d_we2_drop", d_we2, 1'b0);
    step();
    chk("d_busy", d_busy, 1'b0);
    chk("d_irq_off", d_irq, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
